// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the sigmoid datapath and its shared divider scheduler.
package sigmoid_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;

  localparam int EXC_INVALID = 4;
  localparam logic [31:0] ONE_F32  = 32'h3f800000;
  localparam logic [31:0] HALF_F32 = 32'h3f000000;
  localparam int FP_MAX_W = 64;

  // Canonical quiet NaN: sign 0, exponent all ones, top stored mantissa bit set.
  function automatic logic [FP_MAX_W-1:0] FP_QNAN(input int exp_w, input int mant_w);
    logic [FP_MAX_W-1:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << (mant_w - 1);
    r = r | (64'd1 << (mant_w - 2));
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the caller owns the priority pointer register.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Scan N positions starting at ptr; the first requester seen wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    if (en) begin
      for (int off = 0; off < N; off++) begin
        sum = {1'b0, ptr} + (IW+1)'(off);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        idx = sum[IW-1:0];
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
        end
      end
    end
  end

endmodule

// File: rtl/div_share_sched.sv
// Time-shares one iterative FP divider between NUM_REQ requesters, one job in flight,
// with a watchdog that cancels a stalled division and returns a quiet NaN.
module div_share_sched
  import sigmoid_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int exp_width  = 8,
  parameter int mant_width = 24,
  parameter int TIMEOUT    = 64,
  localparam int W = exp_width + mant_width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0] req_rm,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [W-1:0]         resp_data,
  output logic [4:0]           resp_exc,
  output logic                 div_in_valid,
  input  logic                 div_in_ready,
  output logic [W-1:0]         div_a,
  output logic [W-1:0]         div_b,
  output logic [2:0]           div_rm,
  output logic                 div_cancel,
  input  logic                 div_out_valid,
  input  logic [W-1:0]         div_out,
  input  logic [4:0]           div_exc,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [W-1:0] QNAN        = W'(FP_QNAN(exp_width, mant_width));
  localparam logic [4:0]   EXC_TIMEOUT = 5'(1 << EXC_INVALID);

  sched_state_t  state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] g_idx;
  logic [IW-1:0] gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [WW-1:0] wdog;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [2:0]    op_rm;

  // Grants are suppressed during reset so no requester sees a phantom handshake.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      ((state == IDLE) && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign div_a     = op_a;
  assign div_b     = op_b;
  assign div_rm    = op_rm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      g_idx        <= '0;
      wdog         <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_rm        <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      resp_exc     <= '0;
      div_in_valid <= 1'b0;
      div_cancel   <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      div_cancel <= 1'b0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            g_idx        <= gnt_idx;
            op_a         <= req_a[gnt_idx*W +: W];
            op_b         <= req_b[gnt_idx*W +: W];
            op_rm        <= req_rm[gnt_idx*3 +: 3];
            ptr          <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            div_in_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (div_in_ready) begin
            div_in_valid <= 1'b0;
            wdog         <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // A result arriving on the last watchdog cycle is still taken; no cancel is sent.
          if (div_out_valid) begin
            resp_data  <= div_out;
            resp_exc   <= div_exc;
            resp_valid <= NUM_REQ'(1) << g_idx;
            state      <= RESP;
          end else if (wdog == WW'(TIMEOUT-1)) begin
            div_cancel  <= 1'b1;
            timeout_err <= 1'b1;
            resp_data   <= QNAN;
            resp_exc    <= EXC_TIMEOUT;
            resp_valid  <= NUM_REQ'(1) << g_idx;
            state       <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[g_idx]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_sched.sv
// Directed bench for div_share_sched with a latency-programmable divider model and a response scoreboard.
module tb_div_share_sched;
  import sigmoid_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_rm;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic [W-1:0]   resp_data;
  logic [4:0]     resp_exc;
  logic           div_in_valid;
  logic           div_in_ready;
  logic [W-1:0]   div_a;
  logic [W-1:0]   div_b;
  logic [2:0]     div_rm;
  logic           div_cancel;
  logic           div_out_valid = 1'b0;
  logic [W-1:0]   div_out = '0;
  logic [4:0]     div_exc = '0;
  logic           busy;
  logic           timeout_err;

  typedef struct {
    int          lane;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] q;
    logic [4:0]  exc;
  } job_t;

  job_t exp_q[$];
  job_t iss_q[$];
  int checks = 0;
  int errors = 0;
  int resp_count = 0;
  int cancel_count = 0;
  int div_lat = 2;

  div_share_sched #(.NUM_REQ(N), .exp_width(8), .mant_width(24), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_exc(resp_exc),
    .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
    .div_a(div_a), .div_b(div_b), .div_rm(div_rm),
    .div_cancel(div_cancel),
    .div_out_valid(div_out_valid), .div_out(div_out), .div_exc(div_exc),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hand-computed IEEE single quotients for every operand pair the bench uses.
  function automatic logic [36:0] div_lookup(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3f800000_40000000: return {5'h00, 32'h3f000000};
      64'h3f800000_40400000: return {5'h01, 32'h3eaaaaab};
      64'h40c00000_40000000: return {5'h00, 32'h40400000};
      64'h3f800000_00000000: return {5'h08, 32'h7f800000};
      64'h41000000_40800000: return {5'h00, 32'h40000000};
      64'h40000000_40800000: return {5'h00, 32'h3f000000};
      64'hbf800000_40000000: return {5'h00, 32'hbf000000};
      default:               return {5'h1f, 32'hdeadbeef};
    endcase
  endfunction

  logic [36:0] m_res = '0;
  int          m_remain = 0;
  logic        m_busy = 1'b0;

  // Divider model: result appears div_lat cycles after the input handshake; div_lat 0 never answers.
  always @(posedge clk) begin
    if (rst || div_cancel) begin
      m_busy        <= 1'b0;
      m_remain      <= 0;
      div_out_valid <= 1'b0;
    end else begin
      div_out_valid <= 1'b0;
      if (div_in_valid && div_in_ready) begin
        if (div_lat == 1) begin
          div_out_valid      <= 1'b1;
          {div_exc, div_out} <= div_lookup(div_a, div_b);
        end else if (div_lat > 1) begin
          m_busy   <= 1'b1;
          m_remain <= div_lat - 1;
          m_res    <= div_lookup(div_a, div_b);
        end
      end else if (m_busy) begin
        if (m_remain == 1) begin
          div_out_valid      <= 1'b1;
          {div_exc, div_out} <= m_res;
          m_busy             <= 1'b0;
        end else begin
          m_remain <= m_remain - 1;
        end
      end
    end
  end

  task automatic check_issue();
    job_t j;
    if (iss_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL issue_unexpected: got div_a %0h, expected no issue", div_a);
    end else begin
      j = iss_q.pop_front();
      check_output("issue_a", div_a, j.a);
      check_output("issue_b", div_b, j.b);
      check_output("issue_rm", div_rm, j.rm);
    end
  endtask

  task automatic check_resp();
    job_t j;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL resp_unexpected: got resp_valid %b, expected none", resp_valid);
    end else begin
      j = exp_q.pop_front();
      check_output("resp_lane", resp_valid, 64'(1 << j.lane));
      check_output("resp_data", resp_data, j.q);
      check_output("resp_exc", resp_exc, j.exc);
    end
    resp_count++;
  endtask

  // Monitor: checks every divider issue and every completed response transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (div_cancel) cancel_count++;
      if (div_in_valid && div_in_ready) check_issue();
      if ((resp_valid & resp_ready) != '0) check_resp();
    end
  end

  task automatic apply_stimulus(input int lane, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] q, input logic [4:0] exc);
    job_t j;
    j.lane = lane; j.a = a; j.b = b; j.rm = 3'(lane + 1); j.q = q; j.exc = exc;
    exp_q.push_back(j);
    iss_q.push_back(j);
    req_a[lane*W +: W]  = a;
    req_b[lane*W +: W]  = b;
    req_rm[lane*3 +: 3] = j.rm;
  endtask

  // Waits for any grant, checks it went to lane, then steps past the accepting edge.
  task automatic wait_grant(input int lane, input string name);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_output(name, req_ready, 64'(1 << lane));
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input int target, input string name);
    int n = 0;
    while (resp_count < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_output(name, resp_count, target);
  endtask

  logic [31:0] t2_a [4] = '{32'h3f800000, 32'h40c00000, 32'h3f800000, 32'h41000000};
  logic [31:0] t2_b [4] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h40800000};
  logic [31:0] t2_q [4] = '{32'h3eaaaaab, 32'h40400000, 32'h7f800000, 32'h40000000};
  logic [4:0]  t2_e [4] = '{5'h01, 5'h00, 5'h08, 5'h00};

  initial begin
    int n;
    int c0;
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_rm = '0;
    resp_ready = '1; div_in_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("rst_busy", busy, 0);
    check_output("rst_resp_valid", resp_valid, 0);
    check_output("rst_div_in_valid", div_in_valid, 0);
    check_output("rst_timeout_err", timeout_err, 0);

    // T1: single job, latency measured from accept cycle
    div_lat = 5;
    apply_stimulus(0, ONE_F32, 32'h40000000, HALF_F32, 5'h00);
    req_valid[0] = 1'b1;
    wait_grant(0, "t1_grant");
    req_valid[0] = 1'b0;
    n = 1;
    while (resp_valid == '0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("t1_latency", n, 7);
    wait_resp(1, "t1_done");

    div_lat = 1;
    apply_stimulus(3, 32'h41000000, 32'h40800000, 32'h40000000, 5'h00);
    req_valid[3] = 1'b1;
    wait_grant(3, "fill_grant");
    req_valid[3] = 1'b0;
    wait_resp(2, "fill_done");

    // T2: all lanes requesting, grants must rotate
    div_lat = 2;
    for (int k = 0; k < 8; k++) apply_stimulus(k % 4, t2_a[k%4], t2_b[k%4], t2_q[k%4], t2_e[k%4]);
    req_valid = '1;
    for (int k = 0; k < 8; k++) wait_grant(k % 4, "t2_grant_order");
    req_valid = '0;
    wait_resp(10, "t2_done");

    // T3: divider input stall, then response backpressure
    div_in_ready = 1'b0;
    resp_ready[1] = 1'b0;
    apply_stimulus(1, 32'h40000000, 32'h40800000, 32'h3f000000, 5'h00);
    apply_stimulus(2, 32'hbf800000, 32'h40000000, 32'hbf000000, 5'h00);
    req_valid[1] = 1'b1;
    wait_grant(1, "t3_grant");
    req_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_output("t3_in_valid_held", div_in_valid, 1);
      check_output("t3_div_a_stable", div_a, 32'h40000000);
      check_output("t3_div_b_stable", div_b, 32'h40800000);
      @(posedge clk); #1;
    end
    div_in_ready = 1'b1;
    n = 0;
    while (resp_valid == '0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_output("t3_resp_held", resp_valid, 4'b0010);
      check_output("t3_data_held", resp_data, 32'h3f000000);
      check_output("t3_no_grant", req_ready, 0);
      @(posedge clk); #1;
    end
    resp_ready[1] = 1'b1;
    #1;
    check_output("t3_bubble", req_ready, 0);
    @(posedge clk); #1;
    check_output("t3_next_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_resp(12, "t3_done");

    // T5: result on the last watchdog cycle wins over the cancel
    div_lat = TO;
    c0 = cancel_count;
    apply_stimulus(0, 32'h40000000, 32'h40800000, 32'h3f000000, 5'h00);
    req_valid[0] = 1'b1;
    wait_grant(0, "t5_grant");
    req_valid[0] = 1'b0;
    wait_resp(13, "t5_done");
    check_output("t5_no_cancel", cancel_count - c0, 0);
    check_output("t5_no_timeout_err", timeout_err, 0);

    // T4: divider never answers
    div_lat = 0;
    c0 = cancel_count;
    apply_stimulus(1, ONE_F32, 32'h40000000, 32'h7fc00000, 5'h10);
    req_valid[1] = 1'b1;
    wait_grant(1, "t4_grant");
    req_valid[1] = 1'b0;
    n = 0;
    while (!(div_in_valid && div_in_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    n = 0;
    while (!div_cancel && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("t4_cancel_cycle", n, TO);
    wait_resp(14, "t4_done");
    repeat (5) @(posedge clk);
    #1;
    check_output("t4_cancel_once", cancel_count - c0, 1);
    check_output("t4_timeout_err_sticky", timeout_err, 1);

    // T6: reset while waiting on the divider abandons the job
    apply_stimulus(1, ONE_F32, 32'h00000000, 32'h7f800000, 5'h08);
    req_valid[1] = 1'b1;
    wait_grant(1, "t6_grant");
    req_valid[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("t6_req_ready", req_ready, 0);
    check_output("t6_resp_valid", resp_valid, 0);
    check_output("t6_busy", busy, 0);
    check_output("t6_div_in_valid", div_in_valid, 0);
    check_output("t6_div_cancel", div_cancel, 0);
    check_output("t6_timeout_err", timeout_err, 0);
    check_output("t6_resp_data", resp_data, 0);
    check_output("t6_div_a", div_a, 0);
    div_lat = 2;
    apply_stimulus(0, 32'h40c00000, 32'h40000000, 32'h40400000, 5'h00);
    apply_stimulus(2, 32'h41000000, 32'h40800000, 32'h40000000, 5'h00);
    req_valid = 4'b0101;
    wait_grant(0, "t6_ptr_reset_grant");
    req_valid[0] = 1'b0;
    wait_grant(2, "t6_second_grant");
    req_valid[2] = 1'b0;
    wait_resp(16, "t6_done");

    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 500000");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
